simd_alu_pipe: RTL and testbench
================================

// Module: simd_alu_pipe
// PURPOSE
//  Parametrised, two-stage pipelined SIMD add/sub ALU; next generation of the single-word simd_pkg ALU.
//  Operates on W-bit vectors as W/32 independent 32-bit words, each split per op into 1x32, 2x16 or 4x8 elements.
//  Adds a per-transaction saturation mode, per-element carry flags, an illegal-op flag and valid/ready flow control.
//  Sits between the operand-read stage and the writeback stage of the vector datapath.
// PARAMETERS
//  W       32   datapath width in bits; legal values are 32, 64, 128 or 256. Must be a multiple of 32.
//  NB      W/8  derived byte-lane count (localparam, not overridable)
// PORTS
//  clk      in   1    clock
//  rst      in   1    asynchronous reset, active-high
//  in_vld   in   1    operand/op valid
//  in_rdy   out  1    pipeline can accept a transaction this cycle
//  in_op    in   4    opcode; simd_pkg::op_t encoding
//  in_sat   in   2    00 wrap, 01 unsigned saturate, 10 signed saturate, 11 treated as wrap
//  in_a     in   W    operand A
//  in_b     in   W    operand B
//  out_vld  out  1    result valid
//  out_rdy  in   1    downstream accepts result
//  out_y    out  W    result vector
//  out_c    out  NB   carry-out per element, placed at the element's top byte; all other bits 0
//  out_ill  out  1    in_op was 4'b1100..4'b1111 for this result
// BEHAVIOUR
//  Reset (async, rst=1): S1/S2 valid bits cleared -> out_vld=0; out_y=0, out_c=0, out_ill=0. Datapath regs are don't-care except these outputs.
//  Transfer rules
//   - A transfer occurs on a cycle where vld&rdy are both high at that port.
//   - in_rdy = !s1_vld | !s2_vld | out_rdy; this is a combinational function of state and out_rdy only, and never depends on in_vld.
//   - S2 loads from S1 when !s2_vld | out_rdy. S1 loads from the input on any input transfer.
//   - Latency is 2 cycles: a transfer at edge N gives out_vld at edge N+2 if there is no stall.
//   - Throughput is 1 transaction per cycle while out_rdy=1.
//   - out_* are held stable while out_vld & !out_rdy.
//   - Once out_vld is asserted, it only drops after an output transfer.
//  S1 (registered after edge 1)
//   - Performs a byte-sliced 9-bit add of a and (b^inv) with carry-in inv.
//   - The carry between adjacent bytes is propagated only when both bytes lie in the same element. A byte that starts an element takes carry-in = inv for that element.
//   - Stores the 8 sum bits and the carry for each byte (the simd_byte_t layout), plus the op, sat mode and element map.
//  Element map per 32-bit word (element e covers bits [e*size +: size])
//   - SEL0: y=a. SEL1: y=b. For both, out_c=0 and sat is ignored.
//   - ADD32/SUB32: one 32-bit element.
//   - ADD16/SUB16: two 16-bit elements.
//   - ADD8/SUB8: four 8-bit elements.
//   - ADDSUB16: bits[31:16] = a+b, bits[15:0] = a-b. SUBADD16 is the mirror of this.
//   - ADDSUB8: odd bytes = a+b, even bytes = a-b. SUBADD8 is the mirror of this.
//   - Subtract is a+~b+1, so carry=1 means no borrow.
//   - Illegal op: y=0, out_c=0, out_ill=1.
//  S2 (saturation and output register), applied per element
//   - Wrap: y = raw sum.
//   - Unsigned saturate: add with carry=1 gives all-ones; sub with carry=0 gives 0.
//   - Signed saturate: overflow = (msb_a == msb_b') & (msb_sum != msb_a), where b' is the inverted b on sub.
//     On overflow, the result is 0x7F..F if msb_a=0 and 0x80..0 if msb_a=1.
//   - out_c always reports the raw carry, independent of saturation.
//  Boundaries
//   - Full pipe with out_rdy=0: in_rdy=0 and the input is ignored.
//   - out_rdy=1 on the same cycle as a full pipe: in_rdy=1; S2, S1 and the input all advance.
//   - Bubbles (in_vld=0) propagate as invalid slots and never produce spurious out_vld.
//   - rst asserted mid-stream discards all in-flight transactions. The first transfer after release completes 2 cycles later.
//   - W>32: every 32-bit word uses the same op/sat. No carry crosses 32-bit word boundaries.
// TESTING
//  1. ADD32, wrap, a=FFFF_FFFF, b=1 -> y=0000_0000, out_c=4'b1000, out_vld two cycles after transfer.
//  2. ADD8, unsigned sat, a=80_FF_10_01, b=80_01_10_FF -> y=FF_FF_20_FF, out_c=4'b1101.
//  3. SUB16, signed sat, a=8000_7FFF, b=0001_FFFF -> y=8000_8000? no: hi=8000-1 overflow -> 8000; lo=7FFF-(-1) overflow -> 7FFF.
//  4. ADDSUB8, wrap, a=05_05_05_05, b=01_01_01_01 -> y=06_04_06_04. Op 4'b1110 -> y=0, out_ill=1.
//  5. Back-to-back stream of 8 transfers with out_rdy toggling 1,0,0,1,...
//     -> no loss or duplication, in-order results, in_rdy=0 only when both stages are full and out_rdy=0.
//  6. W=128, ADD16 with carry out of bit 31 -> bit 32 is unaffected. Assert rst mid-stream -> out_vld=0 immediately; next result has correct latency.

Source files
------------

// File: rtl/simd_alu_pipe.sv
// rtl/simd_alu_pipe.sv - two-stage pipelined SIMD add/sub ALU with saturation and valid/ready flow control
module simd_alu_pipe #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic [3:0]     in_op,
    input  logic [1:0]     in_sat,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [W-1:0]   out_y,
    output logic [W/8-1:0] out_c,
    output logic           out_ill
);
    localparam int NB = W / 8;

    localparam logic [3:0] OP_SEL0     = 4'd0;
    localparam logic [3:0] OP_SEL1     = 4'd1;
    localparam logic [3:0] OP_ADD32    = 4'd2;
    localparam logic [3:0] OP_SUB32    = 4'd3;
    localparam logic [3:0] OP_ADD16    = 4'd4;
    localparam logic [3:0] OP_SUB16    = 4'd5;
    localparam logic [3:0] OP_ADD8     = 4'd6;
    localparam logic [3:0] OP_SUB8     = 4'd7;
    localparam logic [3:0] OP_ADDSUB16 = 4'd8;
    localparam logic [3:0] OP_SUBADD16 = 4'd9;
    localparam logic [3:0] OP_ADDSUB8  = 4'd10;
    localparam logic [3:0] OP_SUBADD8  = 4'd11;

    logic          w_s2_en;
    logic          w_in_xfer;
    logic [3:0]    w_start;
    logic [3:0]    w_inv;
    logic [1:0]    w_size;
    logic          w_sel_a;
    logic          w_sel_b;
    logic          w_ill;
    logic [W-1:0]  w_sum;
    logic [NB-1:0] w_cy;
    logic [NB-1:0] w_am;
    logic [NB-1:0] w_bm;
    logic [7:0]    w_bx;
    logic [8:0]    w_t;
    logic          w_cin;
    logic          w_cprev;

    logic          r_s1_vld;
    logic [W-1:0]  r_s1_sum;
    logic [NB-1:0] r_s1_cy;
    logic [NB-1:0] r_s1_am;
    logic [NB-1:0] r_s1_bm;
    logic [3:0]    r_s1_inv;
    logic [1:0]    r_s1_size;
    logic [1:0]    r_s1_sat;
    logic          r_s1_arith;
    logic          r_s1_ill;

    logic          r_s2_vld;
    logic [W-1:0]  r_y;
    logic [NB-1:0] r_c;
    logic          r_ill;

    logic [W-1:0]  w_y;
    logic [NB-1:0] w_c;
    logic [1:0]    w_j;
    logic [1:0]    w_top;
    int            w_tk;
    logic          w_ec;
    logic          w_einv;
    logic          w_istop;
    logic          w_ovf;
    logic          w_asign;

    assign in_rdy    = !r_s1_vld || !r_s2_vld || out_rdy;
    assign w_s2_en   = !r_s2_vld || out_rdy;
    assign w_in_xfer = in_vld && in_rdy;
    assign out_vld   = r_s2_vld;
    assign out_y     = r_y;
    assign out_c     = r_c;
    assign out_ill   = r_ill;

    // Byte map of one 32-bit word: w_start marks element-starting bytes, w_inv marks subtracting bytes.
    always_comb begin
        w_start = 4'b1111;
        w_inv   = 4'b0000;
        w_size  = 2'd0;
        w_sel_a = 1'b0;
        w_sel_b = 1'b0;
        w_ill   = 1'b0;
        case (in_op)
            OP_SEL0:     w_sel_a = 1'b1;
            OP_SEL1:     w_sel_b = 1'b1;
            OP_ADD32:    begin w_size = 2'd2; w_start = 4'b0001; end
            OP_SUB32:    begin w_size = 2'd2; w_start = 4'b0001; w_inv = 4'b1111; end
            OP_ADD16:    begin w_size = 2'd1; w_start = 4'b0101; end
            OP_SUB16:    begin w_size = 2'd1; w_start = 4'b0101; w_inv = 4'b1111; end
            OP_ADD8:     w_size = 2'd0;
            OP_SUB8:     w_inv = 4'b1111;
            OP_ADDSUB16: begin w_size = 2'd1; w_start = 4'b0101; w_inv = 4'b0011; end
            OP_SUBADD16: begin w_size = 2'd1; w_start = 4'b0101; w_inv = 4'b1100; end
            OP_ADDSUB8:  w_inv = 4'b0101;
            OP_SUBADD8:  w_inv = 4'b1010;
            default:     w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_sum   = '0;
        w_cy    = '0;
        w_am    = '0;
        w_bm    = '0;
        w_bx    = '0;
        w_t     = '0;
        w_cin   = 1'b0;
        w_cprev = 1'b0;
        for (int k = 0; k < NB; k++) begin
            w_bx           = in_b[k*8 +: 8] ^ {8{w_inv[k%4]}};
            w_cin          = w_start[k%4] ? w_inv[k%4] : w_cprev;
            w_t            = {1'b0, in_a[k*8 +: 8]} + {1'b0, w_bx} + {8'd0, w_cin};
            w_sum[k*8 +: 8] = w_t[7:0];
            w_cy[k]        = w_t[8];
            w_cprev        = w_t[8];
            w_am[k]        = in_a[k*8+7];
            w_bm[k]        = w_bx[7];
        end
        if (w_sel_a) begin
            w_sum = in_a;
            w_cy  = '0;
        end else if (w_sel_b) begin
            w_sum = in_b;
            w_cy  = '0;
        end else if (w_ill) begin
            w_sum = '0;
            w_cy  = '0;
        end
    end

    // Saturation decisions come from each element's top byte and are broadcast to all its bytes.
    always_comb begin
        w_y     = '0;
        w_c     = '0;
        w_j     = '0;
        w_top   = '0;
        w_tk    = 0;
        w_ec    = 1'b0;
        w_einv  = 1'b0;
        w_istop = 1'b0;
        w_ovf   = 1'b0;
        w_asign = 1'b0;
        for (int k = 0; k < NB; k++) begin
            w_j     = 2'(k % 4);
            w_top   = (r_s1_size == 2'd2) ? 2'd3 : (r_s1_size == 2'd1) ? {w_j[1], 1'b1} : w_j;
            w_tk    = (k / 4) * 4 + int'(w_top);
            w_ec    = r_s1_cy[w_tk];
            w_einv  = r_s1_inv[w_top];
            w_istop = (w_top == w_j);
            w_asign = r_s1_am[w_tk];
            w_ovf   = (r_s1_am[w_tk] == r_s1_bm[w_tk]) && (r_s1_sum[w_tk*8+7] != r_s1_am[w_tk]);
            w_y[k*8 +: 8] = r_s1_sum[k*8 +: 8];
            if (r_s1_arith) begin
                if (r_s1_sat == 2'b01) begin
                    if (w_ec && !w_einv)
                        w_y[k*8 +: 8] = 8'hFF;
                    else if (!w_ec && w_einv)
                        w_y[k*8 +: 8] = 8'h00;
                end else if (r_s1_sat == 2'b10 && w_ovf) begin
                    w_y[k*8 +: 8] = w_istop ? {w_asign, {7{!w_asign}}} : {8{!w_asign}};
                end
                w_c[k] = w_istop && r_s1_cy[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_cy    <= '0;
            r_s1_am    <= '0;
            r_s1_bm    <= '0;
            r_s1_inv   <= '0;
            r_s1_size  <= '0;
            r_s1_sat   <= '0;
            r_s1_arith <= 1'b0;
            r_s1_ill   <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_y        <= '0;
            r_c        <= '0;
            r_ill      <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_s1_vld   <= 1'b1;
                r_s1_sum   <= w_sum;
                r_s1_cy    <= w_cy;
                r_s1_am    <= w_am;
                r_s1_bm    <= w_bm;
                r_s1_inv   <= w_inv;
                r_s1_size  <= w_size;
                r_s1_sat   <= in_sat;
                r_s1_arith <= !(w_sel_a || w_sel_b || w_ill);
                r_s1_ill   <= w_ill;
            end else if (w_s2_en) begin
                r_s1_vld <= 1'b0;
            end
            if (w_s2_en) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_y   <= w_y;
                    r_c   <= w_c;
                    r_ill <= r_s1_ill;
                end
            end
        end
    end
endmodule

// File: tb/tb_simd_alu_pipe.sv
// tb/tb_simd_alu_pipe.sv - scoreboard bench for simd_alu_pipe at W=32 and W=128
module tb_simd_alu_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [3:0]  in_op;
    logic [1:0]  in_sat;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_vld;
    logic        out_rdy = 1'b1;
    logic [31:0] out_y;
    logic [3:0]  out_c;
    logic        out_ill;

    logic         in_vld_w;
    logic         in_rdy_w;
    logic [3:0]   in_op_w;
    logic [1:0]   in_sat_w;
    logic [127:0] in_a_w;
    logic [127:0] in_b_w;
    logic         out_vld_w;
    logic         out_rdy_w;
    logic [127:0] out_y_w;
    logic [15:0]  out_c_w;
    logic         out_ill_w;

    simd_alu_pipe #(.W(32)) u_dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_op(in_op), .in_sat(in_sat),
        .in_a(in_a), .in_b(in_b), .out_vld(out_vld), .out_rdy(out_rdy), .out_y(out_y),
        .out_c(out_c), .out_ill(out_ill)
    );

    simd_alu_pipe #(.W(128)) u_dut_w (
        .clk(clk), .rst(rst), .in_vld(in_vld_w), .in_rdy(in_rdy_w), .in_op(in_op_w), .in_sat(in_sat_w),
        .in_a(in_a_w), .in_b(in_b_w), .out_vld(out_vld_w), .out_rdy(out_rdy_w), .out_y(out_y_w),
        .out_c(out_c_w), .out_ill(out_ill_w)
    );

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  sat;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [3:0]  c;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  c;
        logic        ill;
    } exp_t;

    vec_t  tbl[19];
    exp_t  q[$];
    exp_t  pend;
    exp_t  e;
    int    passed = 0;
    int    total  = 0;
    int    rdy_mode = 0;
    int    cyc = 0;
    bit    prev_stall = 1'b0;
    logic [36:0] prev_out;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            passed++;
    endtask

    // out_rdy patterns: 0 always ready, 1 repeating 1,0,0,1, 2 never ready.
    always @(posedge clk) begin
        #2;
        out_rdy = (rdy_mode == 0) || (rdy_mode == 1 && (cyc % 4 == 0 || cyc % 4 == 3));
        cyc++;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("in_rdy", in_rdy, (q.size() < 2) || out_rdy);
            if (prev_stall)
                check("hold", {out_vld, out_ill, out_c, out_y}, {1'b1, prev_out});
            if (out_vld && out_rdy) begin
                if (q.size() == 0) begin
                    check("spurious_vld", out_vld, 1'b0);
                end else begin
                    e = q.pop_front();
                    check("result", {out_ill, out_c, out_y}, {e.ill, e.c, e.y});
                end
            end
            if (in_vld && in_rdy)
                q.push_back(pend);
            prev_stall = out_vld && !out_rdy;
            prev_out   = {out_ill, out_c, out_y};
        end
    end

    task automatic send(input vec_t v);
        bit ok = 1'b0;
        in_op  = v.op;
        in_sat = v.sat;
        in_a   = v.a;
        in_b   = v.b;
        pend   = '{v.y, v.c, v.ill};
        in_vld = 1'b1;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            ok = in_rdy;
        end
        check("send_accept", ok, 1'b1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic drain();
        rdy_mode = 0;
        for (int n = 0; n < 60 && q.size() != 0; n++)
            @(negedge clk);
        @(negedge clk);
        check("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic lat_test(input vec_t v, input string nm);
        in_op  = v.op;
        in_sat = v.sat;
        in_a   = v.a;
        in_b   = v.b;
        pend   = '{v.y, v.c, v.ill};
        in_vld = 1'b1;
        @(negedge clk);
        check({nm, "_rdy"}, in_rdy, 1'b1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        @(negedge clk);
        check({nm, "_vld_edge1"}, out_vld, 1'b0);
        @(negedge clk);
        check({nm, "_vld_edge2"}, out_vld, 1'b1);
        check({nm, "_y"}, out_y, v.y);
        @(posedge clk);
        #1;
    endtask

    task automatic run128(input logic [3:0] op, input logic [1:0] sat, input logic [127:0] a,
                          input logic [127:0] b, input logic [127:0] y, input logic [15:0] c,
                          input string nm);
        in_op_w   = op;
        in_sat_w  = sat;
        in_a_w    = a;
        in_b_w    = b;
        out_rdy_w = 1'b1;
        in_vld_w  = 1'b1;
        @(negedge clk);
        check({nm, "_rdy"}, in_rdy_w, 1'b1);
        @(posedge clk);
        #1;
        in_vld_w = 1'b0;
        @(negedge clk);
        check({nm, "_vld_edge1"}, out_vld_w, 1'b0);
        @(negedge clk);
        check({nm, "_vld_edge2"}, out_vld_w, 1'b1);
        check({nm, "_y"}, out_y_w, y);
        check({nm, "_c"}, out_c_w, c);
        check({nm, "_ill"}, out_ill_w, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_vld = 1'b0; in_op = '0; in_sat = '0; in_a = '0; in_b = '0;
        in_vld_w = 1'b0; in_op_w = '0; in_sat_w = '0; in_a_w = '0; in_b_w = '0; out_rdy_w = 1'b1;
        pend = '{32'h0, 4'h0, 1'b0};

        tbl[0]  = '{4'd2,  2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000, 1'b0};
        tbl[1]  = '{4'd6,  2'd1, 32'h80FF_1001, 32'h8001_10FF, 32'hFFFF_20FF, 4'b1101, 1'b0};
        tbl[2]  = '{4'd5,  2'd2, 32'h8000_7FFF, 32'h0001_FFFF, 32'h8000_7FFF, 4'b1000, 1'b0};
        tbl[3]  = '{4'd10, 2'd0, 32'h0505_0505, 32'h0101_0101, 32'h0604_0604, 4'b0101, 1'b0};
        tbl[4]  = '{4'd14, 2'd0, 32'h0505_0505, 32'h0101_0101, 32'h0000_0000, 4'b0000, 1'b1};
        tbl[5]  = '{4'd0,  2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678, 4'b0000, 1'b0};
        tbl[6]  = '{4'd1,  2'd2, 32'h1234_5678, 32'h9ABC_DEF0, 32'h9ABC_DEF0, 4'b0000, 1'b0};
        tbl[7]  = '{4'd3,  2'd0, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 4'b0000, 1'b0};
        tbl[8]  = '{4'd3,  2'd1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 4'b0000, 1'b0};
        tbl[9]  = '{4'd4,  2'd2, 32'h7FFF_0001, 32'h0001_0001, 32'h7FFF_0002, 4'b0000, 1'b0};
        tbl[10] = '{4'd9,  2'd0, 32'h0010_0010, 32'h0001_0001, 32'h000F_0011, 4'b1000, 1'b0};
        tbl[11] = '{4'd11, 2'd0, 32'h0505_0505, 32'h0101_0101, 32'h0406_0406, 4'b1010, 1'b0};
        tbl[12] = '{4'd7,  2'd1, 32'h1000_FF05, 32'h2001_0105, 32'h0000_FE00, 4'b0011, 1'b0};
        tbl[13] = '{4'd6,  2'd2, 32'h7F80_01FF, 32'h01FF_01FF, 32'h7F80_02FE, 4'b0101, 1'b0};
        tbl[14] = '{4'd12, 2'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0000, 1'b1};
        tbl[15] = '{4'd6,  2'd3, 32'h80FF_1001, 32'h8001_10FF, 32'h0000_2000, 4'b1101, 1'b0};
        tbl[16] = '{4'd4,  2'd0, 32'h0000_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0010, 1'b0};
        tbl[17] = '{4'd8,  2'd0, 32'h0010_0010, 32'h0001_0001, 32'h0011_000F, 4'b0010, 1'b0};
        tbl[18] = '{4'd2,  2'd2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0000, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_out_vld", out_vld, 1'b0);
        check("rst_out_y", out_y, 32'h0);
        check("rst_out_c", out_c, 4'h0);
        check("rst_out_ill", out_ill, 1'b0);
        check("rst_in_rdy", in_rdy, 1'b1);
        check("rst_out_vld_w", out_vld_w, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 19; i++)
            send(tbl[i]);
        drain();

        lat_test(tbl[0], "lat");

        // Fill both stages with out_rdy low, hold a third input against in_rdy=0, then release.
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(tbl[1]);
        send(tbl[2]);
        fork
            send(tbl[3]);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("full_in_rdy", in_rdy, 1'b0);
                end
                @(posedge clk);
                #1;
                rdy_mode = 0;
            end
        join
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 8; i++)
            send(tbl[i + 9]);
        drain();

        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(tbl[5]);
        send(tbl[6]);
        @(negedge clk);
        check("pre_rst_vld", out_vld, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rdy_mode = 0;
        #1;
        check("mid_rst_vld", out_vld, 1'b0);
        check("mid_rst_y", out_y, 32'h0);
        check("mid_rst_c", out_c, 4'h0);
        q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        lat_test(tbl[2], "post_rst");
        drain();

        run128(4'd4, 2'd0,
               {32'h1111_1111, 32'h8000_8000, 32'h0000_1234, 32'hFFFF_0000},
               {32'h1111_1111, 32'h8000_8000, 32'h0000_0001, 32'h0001_0000},
               {32'h2222_2222, 32'h0000_0000, 32'h0000_1235, 32'h0000_0000},
               16'h0A08, "w128_add16");
        run128(4'd2, 2'd1,
               {32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF},
               {32'h0000_0005, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001},
               {32'h0000_0005, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF},
               16'h0008, "w128_add32_usat");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
